mem_unit: RTL and testbench

MEM_UNIT -- requirements
Module: mem_unit

---
 rtl/mem_pkg.sv | 16 +
 rtl/mem_array.sv | 29 ++
 rtl/mem_unit.sv | 102 ++++++++++
 tb/tb_mem_unit.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory unit: FSM encoding, default geometry and
// the wait-counter limits.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int ADDR_W_DEF  = 12;
    localparam int DATA_W_DEF  = 16;
    localparam int LATENCY_MAX = 15;
    localparam int CNT_W       = 4;   // wide enough for LATENCY_MAX-1

endpackage

// File: rtl/mem_array.sv
// Storage array: one synchronous write port and one registered read port.
// There is no reset; contents survive CLR of the controlling unit.
module mem_array #(
    parameter int AW = 12,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/mem_unit.sv
// Fixed-latency memory access unit: accepts one read or write at a time,
// waits LATENCY cycles, then commits/returns data with a one-cycle DONE.
module mem_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int LATENCY = 2
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              RD,
    input  logic              WR,
    input  logic [ADDR_W-1:0] inAR,
    input  logic [DATA_W-1:0] inMEM,
    output logic [DATA_W-1:0] outMEM,
    output logic              BUSY,
    output logic              DONE
);

    // Handshake: a request (RD|WR) is taken at a rising edge only while BUSY
    // is low; requests seen while BUSY is high are dropped, never queued.
    // DONE marks the single cycle in which the access has completed.

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] ar_q;
    logic [DATA_W-1:0] dr_q;
    logic              op_wr;

    logic              commit;
    logic              arr_we;
    logic [ADDR_W-1:0] arr_raddr;
    logic [DATA_W-1:0] arr_rdata;

    assign commit = (state == ST_WAIT) && (cnt == '0);
    assign arr_we = commit && op_wr && !CLR;

    // The read register tracks the access address from the accept edge on,
    // so it already holds the word when the WAIT->DONE edge arrives.
    assign arr_raddr = (state == ST_IDLE) ? inAR : ar_q;

    mem_array #(
        .AW(ADDR_W),
        .DW(DATA_W)
    ) u_array (
        .clk  (CLK),
        .we   (arr_we),
        .waddr(ar_q),
        .wdata(dr_q),
        .raddr(arr_raddr),
        .rdata(arr_rdata)
    );

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            outMEM <= '0;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    DONE <= 1'b0;
                    if (RD || WR) begin
                        ar_q  <= inAR;
                        dr_q  <= inMEM;
                        op_wr <= WR;
                        cnt   <= CNT_LOAD;
                        BUSY  <= 1'b1;
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        DONE  <= 1'b1;
                        state <= ST_DONE;
                        if (!op_wr) begin
                            outMEM <= arr_rdata;
                        end
                    end
                end
                ST_DONE: begin
                    DONE  <= 1'b0;
                    BUSY  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    DONE  <= 1'b0;
                    BUSY  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_unit.sv
// Self-checking bench for mem_unit: three instances (LATENCY 2, 1, 15) with
// directed vectors, a CLR-abort sequence and randomized traffic.
module tb_mem_unit;

    localparam int NI = 3;

    function automatic int lat_of(input int k);
        case (k)
            0:       return 2;
            1:       return 1;
            default: return 15;
        endcase
    endfunction

    logic        clk = 1'b0;
    logic        clr;
    logic        rd   [NI];
    logic        wr   [NI];
    logic [11:0] ar   [NI];
    logic [15:0] din  [NI];
    logic [15:0] dout [NI];
    logic        busy [NI];
    logic        done [NI];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mem_unit #(
            .LATENCY(lat_of(g))
        ) dut (
            .CLK   (clk),
            .CLR   (clr),
            .RD    (rd[g]),
            .WR    (wr[g]),
            .inAR  (ar[g]),
            .inMEM (din[g]),
            .outMEM(dout[g]),
            .BUSY  (busy[g]),
            .DONE  (done[g])
        );
    end

    typedef struct {
        bit          w;
        bit          r;
        bit          poke;
        logic [11:0] a;
        logic [15:0] d;
        logic [15:0] exp;
    } vec_t;

    vec_t        tbl [10];
    logic [15:0] ref_mem [int];
    logic [11:0] wq [$];
    logic [15:0] last_out [NI];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One request on instance k; checks BUSY/DONE timing and returns outMEM
    // as seen during DONE. With poke set, RD is held high while BUSY at 0x020.
    task automatic access(input int k, input bit w, input bit r, input logic [11:0] a,
                          input logic [15:0] d, input bit poke, output logic [15:0] got);
        int l;
        int ndone;
        l     = lat_of(k);
        ndone = 0;
        got   = '0;
        @(negedge clk);
        wr[k] = w; rd[k] = r; ar[k] = a; din[k] = d;
        @(posedge clk); #1;
        wr[k]  = 1'b0;
        rd[k]  = poke;
        ar[k]  = poke ? 12'h020 : 12'($urandom);
        din[k] = 16'($urandom);
        chk($sformatf("busy_at_accept[%0d]", k), 32'(busy[k]), 32'd1);
        chk($sformatf("done_at_accept[%0d]", k), 32'(done[k]), 32'd0);
        for (int n = 1; n <= l + 2; n++) begin
            @(posedge clk); #1;
            if (n == l) rd[k] = 1'b0;
            chk($sformatf("busy[%0d]@t+%0d", k, n), 32'(busy[k]), 32'(n <= l));
            chk($sformatf("done[%0d]@t+%0d", k, n), 32'(done[k]), 32'(n == l));
            if (done[k]) begin
                ndone++;
                got = dout[k];
            end
        end
        chk($sformatf("done_count[%0d]", k), 32'(ndone), 32'd1);
    endtask

    // Applies an op and checks its data against the model; keeps model in step.
    task automatic op_model(input int k, input bit w, input bit r, input logic [11:0] a,
                            input logic [15:0] d, input bit poke);
        logic [15:0] got;
        int key;
        key = k * 4096 + int'(a);
        access(k, w, r, a, d, poke, got);
        if (w) begin
            chk($sformatf("wr_hold_out[%0d] a=%h", k, a), 32'(got), 32'(last_out[k]));
            ref_mem[key] = d;
        end else begin
            chk($sformatf("rd_data[%0d] a=%h", k, a), 32'(got), 32'(ref_mem[key]));
            last_out[k] = ref_mem[key];
        end
    endtask

    initial begin
        logic [15:0] got;
        logic [11:0] a;
        logic [15:0] d;
        bit          w;

        for (int k = 0; k < NI; k++) begin
            rd[k] = 1'b0; wr[k] = 1'b0; ar[k] = '0; din[k] = '0;
            last_out[k] = '0;
        end

        tbl[0] = '{1'b1, 1'b0, 1'b0, 12'h005, 16'hBEEF, 16'h0000};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 12'h005, 16'h0000, 16'hBEEF};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 12'h010, 16'h1234, 16'hBEEF};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 12'h010, 16'h0000, 16'h1234};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 12'h000, 16'h0001, 16'h1234};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 12'hFFF, 16'hFFFF, 16'h1234};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 12'h000, 16'h0000, 16'h0001};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 12'hFFF, 16'h0000, 16'hFFFF};
        tbl[8] = '{1'b1, 1'b0, 1'b0, 12'h030, 16'h5555, 16'hFFFF};
        tbl[9] = '{1'b0, 1'b1, 1'b0, 12'h030, 16'h0000, 16'h5555};

        // Reset
        clr = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("rst_busy[%0d]", k), 32'(busy[k]), 32'd0);
            chk($sformatf("rst_done[%0d]", k), 32'(done[k]), 32'd0);
            chk($sformatf("rst_out[%0d]", k), 32'(dout[k]), 32'd0);
        end
        @(negedge clk);
        clr = 1'b0;

        // Directed vectors on the LATENCY=2 instance
        for (int i = 0; i < 10; i++) begin
            access(0, tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d, tbl[i].poke, got);
            chk($sformatf("vec%0d_out", i), 32'(got), 32'(tbl[i].exp));
            if (tbl[i].w) begin
                ref_mem[int'(tbl[i].a)] = tbl[i].d;
                wq.push_back(tbl[i].a);
            end
            last_out[0] = tbl[i].exp;
        end

        // CLR one edge after accepting a write: write is dropped
        @(negedge clk);
        wr[0] = 1'b1; ar[0] = 12'h030; din[0] = 16'hAAAA;
        @(posedge clk); #1;
        wr[0] = 1'b0;
        chk("abort_busy_accept", 32'(busy[0]), 32'd1);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", 32'(busy[0]), 32'd0);
        chk("abort_done", 32'(done[0]), 32'd0);
        chk("abort_out", 32'(dout[0]), 32'd0);
        @(negedge clk);
        clr = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk); #1;
            chk("abort_no_done", 32'(done[0]), 32'd0);
        end
        last_out[0] = '0;
        op_model(0, 1'b0, 1'b1, 12'h030, 16'h0000, 1'b0);

        // Randomized traffic against the model
        for (int i = 0; i < 40; i++) begin
            w = (wq.size() == 0) || ($urandom_range(0, 1) == 1);
            if (w) begin
                a = ($urandom_range(0, 1) == 1) ? 12'($urandom_range(0, 15)) : 12'($urandom);
                d = 16'($urandom);
                wq.push_back(a);
                op_model(0, 1'b1, 1'($urandom_range(0, 1)), a, d, 1'($urandom_range(0, 1)));
            end else begin
                a = wq[$urandom_range(0, wq.size() - 1)];
                op_model(0, 1'b0, 1'b1, a, 16'($urandom), 1'($urandom_range(0, 1)));
            end
        end

        // LATENCY=1 and LATENCY=15 builds
        for (int k = 1; k < NI; k++) begin
            op_model(k, 1'b1, 1'b0, 12'h123, 16'hC3A5 + 16'(k), 1'b0);
            op_model(k, 1'b1, 1'b0, 12'hFFF, 16'h0F0F, 1'b1);
            op_model(k, 1'b0, 1'b1, 12'h123, 16'h0000, 1'b0);
            op_model(k, 1'b0, 1'b1, 12'hFFF, 16'h0000, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
